reg_ext_fifo: RTL
=================

Name: reg_ext_fifo

Overview:
Parametrised successor to the team's fixed 8→16 and 16→16 load registers. Accepts IN_W-bit words on a load strobe and extends each one to OUT_W bits, sign- or zero-extended per word. Buffers up to DEPTH extended words plus one registered output stage, with a valid/consume handshake. Sits between the datapath load sources and the 16-bit execution registers, so bursts of loads are no longer lost while the consumer is busy.

Parameters:
IN_W, 8, input word width (≥1)
OUT_W, 16, output width (≥ IN_W; equal means plain buffering, no extension)
DEPTH, 4, storage entries behind the output register (≥2, power of two)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
X  in  IN_W  input word
LX  in  1  load/push request
SX  in  1  extension mode sampled with X: 1 = sign-extend from X[IN_W-1], 0 = zero-extend
RD  in  1  consumer takes C this cycle (effective only when vld=1)
CLR  in  1  synchronous flush
C  out  OUT_W  registered output word
vld  out  1  C holds an unconsumed word
full  out  1  storage holds DEPTH words
empty  out  1  storage and output stage both empty
count  out  $clog2(DEPTH+2)  storage occupancy + vld
ovf  out  1  sticky: a push was dropped

Behaviour:
- Reset (rst_n=0, asynchronous): C=0, vld=0, read/write pointers=0, storage count=0, ovf=0. Storage contents are don't-care. Outputs take their reset values immediately, not at the next edge.
- Extension: ext = {OUT_W-IN_W copies of (SX & X[IN_W-1]), X}. It is computed when the push is accepted and stored already extended.
- push = LX & ~full & ~CLR. full is evaluated before any same-cycle pop, so a push while full is dropped even if RD=1.
- LX & full & ~CLR sets ovf=1. ovf clears only on reset or CLR.
- take = RD & vld. RD while vld=0 is ignored.
- Output-stage reload, when ~vld | take:
  - storage non-empty → C ← head, read pointer advances, vld=1;
  - storage empty and push → C ← ext (bypass, 1-cycle LX→vld latency), vld=1, storage unchanged;
  - otherwise → vld=0, C keeps its last value.
- Storage write:
  - A push that does not bypass writes ext at the tail, write pointer advances.
  - Pointers wrap modulo DEPTH.
  - Simultaneous head read and tail write leaves the storage count unchanged.
- Ordering is strict FIFO, including across the bypass path.
- full = (storage count == DEPTH). empty = (storage count == 0) & ~vld. count = storage count + vld. All three are derived from registered state, with no combinational path from LX or RD.
- CLR has priority over LX and RD. Next cycle: storage count=0, pointers=0, vld=0, ovf=0, C holds its value.
- Throughput: one push and one take per cycle are sustained indefinitely when not full.

Decomposition:
- Shared package: extension-mode constants (EXT_ZERO=0, EXT_SIGN=1) and a count-width helper function.
- One combinational sub-module, sign_ext (IN_W, OUT_W, X, SX → ext). It is reusable by the existing converter registers.
- Storage array, pointers and output stage live in reg_ext_fifo itself.

Test Plan:
All scenarios use IN_W=8, OUT_W=16, DEPTH=4.
- Reset: assert rst_n=0 mid-burst with vld=1 → C=0x0000, vld=0, empty=1, count=0, ovf=0 before the next clk edge.
- Extension, single pushes from empty: X=0x85, SX=1 → next cycle C=0xFF85, vld=1, count=1. After a take, X=0x85, SX=0 → C=0x0085. X=0x7F, SX=1 → C=0x007F.
- Fill, RD=0: push 0x01..0x05 → C=0x0001, full=1, count=5. Push 0x06 → dropped, ovf=1, count stays 5. Then hold RD=1 → C=0x0002,0x0003,0x0004,0x0005 on successive cycles, then vld=0, empty=1. ovf stays 1.
- Push and take in the same cycle: C=0x00AA, vld=1, storage empty; LX X=0x0B, SX=0 with RD=1 → next C=0x000B, vld=1, count=1. Continuous LX+RD for 20 cycles → count constant, output order matches input order across pointer wrap.
- Full plus pop: full, LX=1 X=0x33 and RD=1 → push dropped, ovf=1, count=4 next cycle.
- Flush: CLR=1 with LX=1 and RD=1, count=3 → next cycle count=0, vld=0, ovf=0, C unchanged. The following push 0x12, SX=0 → C=0x0012 one cycle later.

Source files
------------

// File: rtl/reg_ext_fifo_pkg.sv
// Shared definitions for the extending load FIFO and its helper blocks.
package reg_ext_fifo_pkg;

  // Extension mode carried alongside each loaded word
  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

  // Width needed to report storage occupancy plus the output-stage word
  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/sign_ext.sv
// Combinational widener: zero- or sign-extends an IN_W word to OUT_W bits.
module sign_ext
  import reg_ext_fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  X,
  input  logic             SX,
  output logic [OUT_W-1:0] ext
);

  generate
    if (OUT_W > IN_W) begin : g_widen
      logic fill;
      // Fill bit is the input MSB only in sign mode
      assign fill = (SX == EXT_SIGN) & X[IN_W-1];
      assign ext  = {{(OUT_W - IN_W){fill}}, X};
    end else begin : g_same
      // Equal widths: plain pass-through, mode has no effect
      logic unused_sx;
      assign unused_sx = SX;
      assign ext       = X;
    end
  endgenerate

endmodule

// File: rtl/reg_ext_fifo.sv
// Load buffer: extends each loaded word, queues up to DEPTH of them behind a
// registered output stage and hands them out with a valid/consume handshake.
module reg_ext_fifo
  import reg_ext_fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [IN_W-1:0]                 X,
  input  logic                            LX,
  input  logic                            SX,
  input  logic                            RD,
  input  logic                            CLR,
  output logic [OUT_W-1:0]                C,
  output logic                            vld,
  output logic                            full,
  output logic                            empty,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int CW = count_width(DEPTH);

  // Storage (contents need no reset) and registered state
  logic [OUT_W-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [SW-1:0]    scnt_q, scnt_d;
  logic [OUT_W-1:0] c_q, c_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic [OUT_W-1:0] ext;
  logic             full_w;
  logic             push;
  logic             take;
  logic             reload;
  logic             pop;
  logic             bypass;
  logic             wr_en;

  sign_ext #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_sign_ext (
    .X   (X),
    .SX  (SX),
    .ext (ext)
  );

  // Status comes only from registered state, so no LX/RD -> status path
  assign full_w = (scnt_q == SW'(DEPTH));
  assign push   = LX & ~full_w & ~CLR;
  assign take   = RD & vld_q;
  assign reload = ~vld_q | take;

  // Next-state: flush first, then output reload (head or bypass), then tail write
  always_comb begin
    c_d    = c_q;
    vld_d  = vld_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    scnt_d = scnt_q;
    ovf_d  = ovf_q;
    pop    = 1'b0;
    bypass = 1'b0;
    wr_en  = 1'b0;
    if (CLR) begin
      scnt_d = '0;
      rd_d   = '0;
      wr_d   = '0;
      vld_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      // A load that finds storage full is lost; remember it
      if (LX && full_w) begin
        ovf_d = 1'b1;
      end
      if (reload) begin
        if (scnt_q != '0) begin
          c_d   = mem[rd_q];
          rd_d  = rd_q + PW'(1);
          vld_d = 1'b1;
          pop   = 1'b1;
        end else if (push) begin
          // Nothing queued ahead of it: skip storage to keep 1-cycle latency
          c_d    = ext;
          vld_d  = 1'b1;
          bypass = 1'b1;
        end else begin
          vld_d = 1'b0;
        end
      end
      if (push && !bypass) begin
        wr_en = 1'b1;
        wr_d  = wr_q + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   scnt_d = scnt_q + SW'(1);
        2'b01:   scnt_d = scnt_q - SW'(1);
        default: scnt_d = scnt_q;
      endcase
    end
  end

  // Control and output-stage registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      scnt_q <= '0;
      c_q    <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      scnt_q <= scnt_d;
      c_q    <= c_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  // Tail write of an already-extended word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_q] <= ext;
    end
  end

  assign C     = c_q;
  assign vld   = vld_q;
  assign full  = full_w;
  assign empty = (scnt_q == '0) & ~vld_q;
  assign count = CW'(scnt_q) + CW'(vld_q);
  assign ovf   = ovf_q;

endmodule
